piso_sched: RTL
===============

PISO_SCHED -- requirements
Module: piso_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width; legal values are WIDTH >= 2.
REQ-002 The block SHALL have parameter DIV, default 1, giving clock cycles per serial bit; legal values are DIV >= 1.
REQ-003 Port clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  is the reset, synchronous and active-high.
REQ-005 Port req0_valid  input  1  means requester 0 has a word to send.
REQ-006 Port req0_data  input  WIDTH  is the word from requester 0.
REQ-007 Port req0_ready  output  1  means the block accepts req0_data this cycle.
REQ-008 Port req1_valid  input  1  means requester 1 has a word to send.
REQ-009 Port req1_data  input  WIDTH  is the word from requester 1.
REQ-010 Port req1_ready  output  1  means the block accepts req1_data this cycle.
REQ-011 Port sout  output  1  is the serial data, LSB first.
REQ-012 Port sout_valid  output  1  is high while sout carries a frame bit.
REQ-013 Port src  output  1  is the requester ID of the frame in progress.
REQ-014 Port done  output  1  is a one-cycle pulse marking the final cycle of a frame.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and GAP.
REQ-016 A handshake SHALL occur on a cycle where reqN_valid and reqN_ready are both 1; data SHALL be sampled only on the handshake cycle.
REQ-017 In IDLE, reqN_ready SHALL be driven combinationally high for at most one requester, the granted one, and only when its valid is high; outside IDLE, both readies SHALL be 0.
REQ-018 Arbitration SHALL be round-robin: the priority pointer reads 0 after reset, and after a grant to N it SHALL point to the other requester; a lone valid requester SHALL be granted regardless of the pointer.
REQ-019 On a handshake at cycle T, the FSM SHALL move to SHIFT, load the shift register with the word, set bit counter and prescaler to 0, and register src = N.
REQ-020 In SHIFT:
- sout_valid SHALL be 1 and sout SHALL equal shreg[0].
- Each bit SHALL be held for DIV cycles, timed by a prescaler that counts 0..DIV-1.
- At prescaler wrap, shreg SHALL shift right with zero fill and the bit counter SHALL increment.
REQ-021 The first bit SHALL appear at cycle T+1, and the last bit SHALL end at cycle T+WIDTH*DIV.
REQ-022 done SHALL be 1 only in the final cycle of the last bit; the FSM SHALL then enter GAP.
REQ-023 GAP SHALL last exactly one cycle with sout=0 and sout_valid=0, followed by IDLE, so the earliest next handshake is at T+WIDTH*DIV+2.
REQ-024 Outside SHIFT, sout, sout_valid and done SHALL be 0; src SHALL hold its last value until the next handshake.
REQ-025 Requester valid dropping without a handshake SHALL have no effect on the FSM or the pointer.
REQ-026 Input changes during SHIFT or GAP SHALL not alter the frame in progress.
REQ-027 Counter widths SHALL be $clog2(WIDTH+1) and $clog2(DIV+1), with no overflow for legal parameter values.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set state=IDLE, shreg=0, counters=0, pointer=0 and src=0.
REQ-029 During reset, sout, sout_valid, done, req0_ready and req1_ready SHALL be 0, regardless of the inputs in the reset cycle.
REQ-030 Reset asserted mid-frame SHALL abort the frame without a done pulse; the aborted word SHALL be discarded.
REQ-031 In the first cycle after rst falls, the block SHALL be in IDLE and able to handshake.

Verification
REQ-032 WIDTH=4, DIV=1, req0 sends 4'b1011 with a handshake at T -> sout=1,1,0,1 at T+1..T+4, sout_valid high for T+1..T+4, done at T+4, src=0, idle at T+5.
REQ-033 After reset, both valid in the same cycle with data 4'h3 and 4'hC -> req0 is served first; req1 handshakes at T+6 and sout=0,0,1,1 at T+7..T+10, src=1.
REQ-034 Both held valid continuously for 4 frames -> src sequence 0,1,0,1 with handshakes spaced 6 cycles apart.
REQ-035 DIV=3, req1 sends 4'b0110 -> each bit is held 3 cycles (sout 0 for T+1..T+3, 1 for T+4..T+9, 0 for T+10..T+12), done at T+12.
REQ-036 rst pulsed during the 2nd bit of a frame -> the next cycle has sout_valid=0, no done pulse and pointer=0; a req1-only request after reset is granted in the first post-reset cycle.
REQ-037 req0 alone, held valid with changing data -> back-to-back frames every WIDTH*DIV+2 cycles, each carrying the data sampled at its handshake.

Source files
------------

// File: rtl/piso_sched.sv
// Two-requester round-robin parallel-to-serial scheduler.
// Each granted word goes out LSB first, one bit per DIV clocks, followed by one idle gap cycle.
module piso_sched #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             src,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(DIV + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [BW-1:0]    bit_reg, bit_next;
  logic [PW-1:0]    pre_reg, pre_next;
  logic             ptr_reg, ptr_next;
  logic             src_reg, src_next;

  logic [1:0]       valid_vec;
  logic [1:0]       ready_vec;
  logic             grant;
  logic             handshake;
  logic [WIDTH-1:0] grant_data;
  logic             in_shift;
  logic             last_tick;

  assign valid_vec = {req1_valid, req0_valid};

  // With both requesting the pointer decides; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (valid_vec == 2'b11) begin
      grant = ptr_reg;
    end else begin
      grant = valid_vec[1];
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      localparam logic ID = 1'(gi);
      assign ready_vec[gi] = (state_reg == IDLE) && !rst && valid_vec[gi] && (grant == ID);
    end
  endgenerate

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign handshake  = |ready_vec;
  assign grant_data = grant ? req1_data : req0_data;

  // Outputs are forced low during the reset cycle even if a frame is still registered.
  assign in_shift   = (state_reg == SHIFT) && !rst;
  assign last_tick  = (bit_reg == BIT_LAST) && (pre_reg == PRE_LAST);
  assign sout       = in_shift && shreg_reg[0];
  assign sout_valid = in_shift;
  assign done       = in_shift && last_tick;
  assign src        = src_reg;

  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    bit_next   = bit_reg;
    pre_next   = pre_reg;
    ptr_next   = ptr_reg;
    src_next   = src_reg;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          state_next = SHIFT;
          shreg_next = grant_data;
          bit_next   = '0;
          pre_next   = '0;
          src_next   = grant;
          ptr_next   = ~grant;
        end
      end
      SHIFT: begin
        if (pre_reg == PRE_LAST) begin
          pre_next   = '0;
          shreg_next = shreg_reg >> 1;
          bit_next   = bit_reg + BW'(1);
          if (bit_reg == BIT_LAST) begin
            state_next = GAP;
          end
        end else begin
          pre_next = pre_reg + PW'(1);
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      bit_reg   <= '0;
      pre_reg   <= '0;
      ptr_reg   <= 1'b0;
      src_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      bit_reg   <= bit_next;
      pre_reg   <= pre_next;
      ptr_reg   <= ptr_next;
      src_reg   <= src_next;
    end
  end

endmodule
